// File: rtl/cpu_datapath.sv
// Register/datapath stage of the 8-bit accumulator CPU: state register, PC/IR/MDR/ACC, ALU and
// memory bus drive. Optional sticky halt freeze is enabled by defining HALT_STOP_EN.
module cpu_datapath #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 5,
    parameter int unsigned OPW    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_ir,
    input  logic              ld_mdr,
    input  logic              ld_acc,
    input  logic              ld_pc,
    input  logic              inc,
    input  logic              sel,
    input  logic              rd,
    input  logic              wr,
    input  logic              dout_en,
    input  logic [2:0]        nstate,
    output logic [2:0]        pstate,
    output logic [OPW-1:0]    op,
    output logic              zero,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_din,
    output logic [DWIDTH-1:0] mem_dout,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] pc_out,
    output logic [DWIDTH-1:0] acc_out,
    output logic              halted
);

    localparam logic [2:0]     StReset = 3'b100;
    localparam logic [2:0]     StExec1 = 3'b010;
    localparam logic [OPW-1:0] OpHalt  = OPW'(0);
    localparam logic [OPW-1:0] OpAdd   = OPW'(2);
    localparam logic [OPW-1:0] OpAnd   = OPW'(3);
    localparam logic [OPW-1:0] OpXor   = OPW'(4);
    localparam logic [OPW-1:0] OpLoad  = OPW'(5);

    logic [2:0]        pstate_q, pstate_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [DWIDTH-1:0] ir_q, ir_d;
    logic [DWIDTH-1:0] mdr_q, mdr_d;
    logic [DWIDTH-1:0] acc_q, acc_d;
    logic [DWIDTH-1:0] alu_res;
    logic [AWIDTH-1:0] ir_addr;
    logic              freeze;

    assign op      = ir_q[DWIDTH-1:DWIDTH-OPW];
    assign ir_addr = ir_q[AWIDTH-1:0];

`ifdef HALT_STOP_EN
    logic halted_q, halted_d;

    assign halted_d = halted_q | ((pstate_q == StExec1) && (op == OpHalt));
    assign freeze   = halted_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q;
`else
    assign freeze = 1'b0;
    assign halted = 1'b0;
`endif

    always_comb begin
        case (op)
            OpAdd:   alu_res = acc_q + mdr_q;
            OpAnd:   alu_res = acc_q & mdr_q;
            OpXor:   alu_res = acc_q ^ mdr_q;
            OpLoad:  alu_res = mdr_q;
            default: alu_res = acc_q;
        endcase
    end

    always_comb begin
        pstate_d = pstate_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        mdr_d    = mdr_q;
        acc_d    = acc_q;
        if (!freeze) begin
            pstate_d = nstate;
            if (ld_ir) begin
                ir_d = mem_din;
            end
            if (ld_mdr) begin
                mdr_d = mem_din;
            end
            // ld_pc wins over inc
            if (ld_pc) begin
                pc_d = ir_addr;
            end else if (inc) begin
                pc_d = pc_q + AWIDTH'(1);
            end
            if (ld_acc) begin
                acc_d = alu_res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pstate_q <= StReset;
            pc_q     <= '0;
            ir_q     <= '0;
            mdr_q    <= '0;
            acc_q    <= '0;
        end else begin
            pstate_q <= pstate_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
            acc_q    <= acc_d;
        end
    end

    assign pstate   = pstate_q;
    assign zero     = (acc_q == '0);
    assign mem_addr = sel ? ir_addr : pc_q;
    assign mem_rd   = rd & ~freeze;
    assign mem_wr   = wr & ~freeze;
    assign mem_dout = dout_en ? acc_q : '0;
    assign pc_out   = pc_q;
    assign acc_out  = acc_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: a small controller and combinational memory run short programs;
// expected PC/ACC per instruction are queued before execution and compared on completion.
module tb_cpu_datapath;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ld_ir, ld_mdr, ld_acc, ld_pc, inc, sel, rd, wr, dout_en;
    logic [2:0] nstate, pstate;
    logic [2:0] op;
    logic       zero;
    logic [4:0] mem_addr, pc_out;
    logic [7:0] mem_din, mem_dout, acc_out;
    logic       mem_rd, mem_wr, halted;

    logic [7:0] mem [32];
    logic       manual;
    logic       m_ld_pc, m_inc;

    int n_tests = 0;
    int n_fail  = 0;

    logic [13:0] sb_q [$];
    logic [4:0]  fetch_addr, ex_addr;
    logic        ex_wr, bad_dout;
    logic [7:0]  ex_dout;

    always #5 clk = ~clk;

    assign mem_din = mem[mem_addr];

    cpu_datapath dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_ir    (ld_ir),
        .ld_mdr   (ld_mdr),
        .ld_acc   (ld_acc),
        .ld_pc    (ld_pc),
        .inc      (inc),
        .sel      (sel),
        .rd       (rd),
        .wr       (wr),
        .dout_en  (dout_en),
        .nstate   (nstate),
        .pstate   (pstate),
        .op       (op),
        .zero     (zero),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .pc_out   (pc_out),
        .acc_out  (acc_out),
        .halted   (halted)
    );

    // Controller: 000 fetch, 001 decode, 010 exec1, 011 exec2, 100 reset.
    always_comb begin
        ld_ir = 1'b0; ld_mdr = 1'b0; ld_acc = 1'b0; ld_pc = 1'b0; inc = 1'b0;
        sel = 1'b0; rd = 1'b0; wr = 1'b0; dout_en = 1'b0; nstate = 3'b000;
        if (manual) begin
            ld_pc  = m_ld_pc;
            inc    = m_inc;
            nstate = 3'b001;
        end else begin
            case (pstate)
                3'b000: begin rd = 1'b1; ld_ir = 1'b1; nstate = 3'b001; end
                3'b001: begin sel = 1'b1; nstate = 3'b010; end
                3'b010: begin
                    sel = 1'b1;
                    nstate = 3'b011;
                    case (op)
                        3'b000: nstate = 3'b000;
                        3'b001: inc = 1'b1;
                        3'b110: begin wr = 1'b1; dout_en = 1'b1; end
                        3'b111: ld_pc = 1'b1;
                        default: begin rd = 1'b1; ld_mdr = 1'b1; end
                    endcase
                end
                3'b011: begin
                    case (op)
                        3'b001: inc = zero;
                        3'b110: inc = 1'b1;
                        3'b111: inc = 1'b0;
                        default: begin ld_acc = 1'b1; inc = 1'b1; end
                    endcase
                end
                default: nstate = 3'b000;
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Call at a negedge with pstate == fetch; returns at the next fetch.
    task automatic exec_instr(input string tag, input logic [4:0] epc, input logic [7:0] eacc);
        logic [13:0] e;
        bit          done;
        sb_q.push_back({epc, eacc, eacc == 8'h00});
        fetch_addr = mem_addr;
        bad_dout   = (mem_dout != 8'h00);
        ex_addr = '0; ex_wr = 1'b0; ex_dout = '0;
        done = 1'b0;
        for (int cyc = 0; cyc < 8 && !done; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (pstate == 3'b010) begin
                ex_addr = mem_addr; ex_wr = mem_wr; ex_dout = mem_dout;
            end else if (mem_dout != 8'h00) begin
                bad_dout = 1'b1;
            end
            if (pstate == 3'b000) done = 1'b1;
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        e = sb_q.pop_front();
        check_eq({tag, "_pc"}, 32'(pc_out), 32'(e[13:9]));
        check_eq({tag, "_acc"}, 32'(acc_out), 32'(e[8:1]));
        check_eq({tag, "_zero"}, 32'(zero), 32'(e[0]));
        check_eq({tag, "_dout_idle"}, 32'(bad_dout), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_pstate"}, 32'(pstate), 32'h4);
        check_eq({tag, "_pc"}, 32'(pc_out), 32'h0);
        check_eq({tag, "_acc"}, 32'(acc_out), 32'h0);
        check_eq({tag, "_zero"}, 32'(zero), 32'h1);
        check_eq({tag, "_op"}, 32'(op), 32'h0);
        check_eq({tag, "_wr"}, 32'(mem_wr), 32'h0);
        check_eq({tag, "_halted"}, 32'(halted), 32'h0);
    endtask

    initial begin
        bit saw_exec;
        manual = 1'b0; m_ld_pc = 1'b0; m_inc = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[0]  = 8'hB0; mem[1] = 8'hB3; mem[2] = 8'h51; mem[3] = 8'h20;
        mem[5]  = 8'hB4; mem[6] = 8'hD2; mem[7] = 8'h20; mem[8] = 8'h75;
        mem[9]  = 8'h96; mem[10] = 8'hEC;
        mem[16] = 8'h2A; mem[17] = 8'h01; mem[19] = 8'hFF; mem[20] = 8'h5A;
        mem[21] = 8'h0F; mem[22] = 8'hFF;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst0");
        rst_n = 1'b1;
        #1 check_eq("rel_pstate_hold", 32'(pstate), 32'h4);
        @(negedge clk);
        check_eq("rel_pstate_fetch", 32'(pstate), 32'h0);

        exec_instr("load", 5'd1, 8'h2A);
        check_eq("load_fetch_addr", 32'(fetch_addr), 32'h00);
        check_eq("load_exec_addr", 32'(ex_addr), 32'h10);
        exec_instr("load_ff", 5'd2, 8'hFF);
        exec_instr("add_wrap", 5'd3, 8'h00);
        exec_instr("skz_taken", 5'd5, 8'h00);
        exec_instr("load_5a", 5'd6, 8'h5A);
        exec_instr("store", 5'd7, 8'h5A);
        check_eq("store_addr", 32'(ex_addr), 32'h12);
        check_eq("store_wr", 32'(ex_wr), 32'h1);
        check_eq("store_dout", 32'(ex_dout), 32'h5A);
        exec_instr("skz_not", 5'd8, 8'h5A);
        exec_instr("and", 5'd9, 8'h0A);
        exec_instr("xor", 5'd10, 8'hF5);
        exec_instr("jmp", 5'd12, 8'hF5);
        exec_instr("halt", 5'd12, 8'hF5);

`ifdef HALT_STOP_EN
        check_eq("halt_flag", 32'(halted), 32'h1);
        repeat (20) @(negedge clk);
        check_eq("halt_frz_pstate", 32'(pstate), 32'h0);
        check_eq("halt_frz_pc", 32'(pc_out), 32'd12);
        check_eq("halt_frz_acc", 32'(acc_out), 32'hF5);
        check_eq("halt_frz_op", 32'(op), 32'h0);
        check_eq("halt_frz_rd", 32'(mem_rd), 32'h0);
        check_eq("halt_flag_sticky", 32'(halted), 32'h1);
`else
        saw_exec = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pstate == 3'b010) saw_exec = 1'b1;
        end
        check_eq("halt_no_flag", 32'(halted), 32'h0);
        check_eq("halt_pc_hold", 32'(pc_out), 32'd12);
        check_eq("halt_refetch", 32'(saw_exec), 32'h1);
`endif

        // Asynchronous reset in the middle of an instruction
        for (int i = 0; i < 8 && pstate != 3'b010 && !halted; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_eq("async_pstate", 32'(pstate), 32'h4);
        mem[0] = 8'hFF; mem[31] = 8'hB0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst_mid");
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel2_pstate_fetch", 32'(pstate), 32'h0);

        exec_instr("jmp31", 5'd31, 8'h00);
        exec_instr("pc_wrap", 5'd0, 8'h2A);

        manual = 1'b1; m_ld_pc = 1'b1; m_inc = 1'b1;
        @(negedge clk);
        check_eq("ldpc_over_inc", 32'(pc_out), 32'd16);
        manual = 1'b0; m_ld_pc = 1'b0; m_inc = 1'b0;

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
